// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction decode pipeline: field positions,
// opcode constants, instruction classes and skid-buffer occupancy states.
package instr_decode_pkg;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int SH_HI   = 15;
    localparam int SH_LO   = 11;
    localparam int FN_HI   = 4;
    localparam int FN_LO   = 0;
    localparam int IMM_MSB = 15;
    localparam int LBL_MSB = 25;

    localparam logic [5:0] OPC_ALU_REG    = 6'd0;
    localparam logic [5:0] OPC_ALU_IMM    = 6'd1;
    localparam logic [5:0] OPC_LOAD       = 6'd2;
    localparam logic [5:0] OPC_STORE      = 6'd3;
    localparam logic [5:0] OPC_BRANCH_REG = 6'd4;
    localparam logic [5:0] OPC_BRANCH_LBL = 6'd5;

    typedef enum logic [2:0] {
        CLS_ALU_REG    = 3'd0,
        CLS_ALU_IMM    = 3'd1,
        CLS_LOAD       = 3'd2,
        CLS_STORE      = 3'd3,
        CLS_BRANCH_REG = 3'd4,
        CLS_BRANCH_LBL = 3'd5,
        CLS_ILLEGAL    = 3'd7
    } instr_class_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic instr_class_e classify(input logic [5:0] opc);
        instr_class_e c;
        case (opc)
            OPC_ALU_REG:    c = CLS_ALU_REG;
            OPC_ALU_IMM:    c = CLS_ALU_IMM;
            OPC_LOAD:       c = CLS_LOAD;
            OPC_STORE:      c = CLS_STORE;
            OPC_BRANCH_REG: c = CLS_BRANCH_REG;
            OPC_BRANCH_LBL: c = CLS_BRANCH_LBL;
            default:        c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipelined_instr_decode_if.sv
// Upstream/downstream bus of the instruction decoder, plus occupancy debug.
interface pipelined_instr_decode_if #(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
);
    // Handshake: a word moves on a rising edge when valid && ready; valid holds
    // its payload steady until then, and ready never depends on valid.
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [5:0]         out_opcode;
    logic [4:0]         out_func;
    logic [REG_W-1:0]   out_rs;
    logic [REG_W-1:0]   out_rt;
    logic [REG_W-1:0]   out_shamt;
    logic [DATA_W-1:0]  out_imm_ext;
    logic [DATA_W-1:0]  out_label_ext;
    logic [2:0]         out_class;
    logic               out_illegal;
    logic [CNT_W-1:0]   decode_count;
    logic [1:0]         dbg_state;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_func, out_rs, out_rt, out_shamt,
               out_imm_ext, out_label_ext, out_class, out_illegal, decode_count, dbg_state
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_func, out_rs, out_rt, out_shamt,
               out_imm_ext, out_label_ext, out_class, out_illegal, decode_count, dbg_state
    );
endinterface

// File: rtl/instr_field_decode.sv
// Pure combinational field extraction, classification and sign extension.
module instr_field_decode
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         func,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   shamt,
    output logic [DATA_W-1:0]  imm_ext,
    output logic [DATA_W-1:0]  label_ext,
    output logic [2:0]         cls,
    output logic               illegal
);
    instr_class_e cls_e;

    always_comb begin
        opcode  = instr[OPC_HI:OPC_LO];
        func    = instr[FN_HI:FN_LO];
        rs      = REG_W'(instr[RS_HI:RS_LO]);
        rt      = REG_W'(instr[RT_HI:RT_LO]);
        shamt   = REG_W'(instr[SH_HI:SH_LO]);
        cls_e   = classify(instr[OPC_HI:OPC_LO]);
        cls     = cls_e;
        illegal = (cls_e == CLS_ILLEGAL);
    end

    // Bit-wise build keeps a narrow DATA_W LSB-aligned and a wide one sign-filled.
    always_comb begin
        imm_ext   = '0;
        label_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            imm_ext[i]   = (i <= IMM_MSB) ? instr[i] : instr[IMM_MSB];
            label_ext[i] = (i <= LBL_MSB) ? instr[i] : instr[LBL_MSB];
        end
    end
endmodule

// File: rtl/pipelined_instr_decode.sv
// Decodes on entry into a two-entry skid buffer; outputs come only from
// registers, and a saturating counter tracks downstream deliveries.
module pipelined_instr_decode
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_instr_decode_if.slave bus
);
    typedef struct packed {
        logic [5:0]        opcode;
        logic [4:0]        func;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  shamt;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] label_ext;
        logic [2:0]        cls;
        logic              illegal;
    } entry_t;

    logic [5:0]        dec_opcode;
    logic [4:0]        dec_func;
    logic [REG_W-1:0]  dec_rs, dec_rt, dec_shamt;
    logic [DATA_W-1:0] dec_imm, dec_label;
    logic [2:0]        dec_cls;
    logic              dec_illegal;
    entry_t            dec, head, tail;

    occ_e             state, state_nxt;
    logic             in_ready_int, out_valid_int;
    logic             accept, deliver, load_head, load_tail, shift;
    logic [CNT_W-1:0] cnt;

    instr_field_decode #(
        .INSTR_W(INSTR_W),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_field_decode (
        .instr    (bus.in_instr),
        .opcode   (dec_opcode),
        .func     (dec_func),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .shamt    (dec_shamt),
        .imm_ext  (dec_imm),
        .label_ext(dec_label),
        .cls      (dec_cls),
        .illegal  (dec_illegal)
    );

    assign dec = {dec_opcode, dec_func, dec_rs, dec_rt, dec_shamt,
                  dec_imm, dec_label, dec_cls, dec_illegal};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OCC_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !deliver)      state_nxt = OCC_TWO;
                    else if (!accept && deliver) state_nxt = OCC_EMPTY;
                end
                OCC_TWO:   if (deliver) state_nxt = OCC_ONE;
                default:   state_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Ready comes from the registered occupancy only, so it never waits on out_ready.
    always_comb begin
        in_ready_int  = !rst && (state != OCC_TWO);
        out_valid_int = (state != OCC_EMPTY);
        accept        = bus.in_valid && in_ready_int && !bus.flush;
        deliver       = out_valid_int && bus.out_ready;
        load_head     = accept && ((state == OCC_EMPTY) || (state == OCC_ONE && deliver));
        load_tail     = accept && (state == OCC_ONE) && !deliver;
        shift         = deliver && (state == OCC_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head)  head <= dec;
            else if (shift) head <= tail;
            if (load_tail)  tail <= dec;
        end
    end

    // A delivery in a flush cycle still happened downstream, so it is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (deliver && cnt != '1) cnt <= cnt + CNT_W'(1);
    end

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = out_valid_int;
    assign bus.out_opcode    = head.opcode;
    assign bus.out_func      = head.func;
    assign bus.out_rs        = head.rs;
    assign bus.out_rt        = head.rt;
    assign bus.out_shamt     = head.shamt;
    assign bus.out_imm_ext   = head.imm_ext;
    assign bus.out_label_ext = head.label_ext;
    assign bus.out_class     = head.cls;
    assign bus.out_illegal   = head.illegal;
    assign bus.decode_count  = cnt;
    assign bus.dbg_state     = state;
endmodule
